// File: rtl/pipeline_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_hazard_unit
//  Description : Hazard and forwarding controller for the 4-stage-plus-WB
//                CPU pipeline.
//                - Zero-latency EX operand forwarding (EX/MEM over MEM/WB),
//                  with optional register-0 suppression.
//                - Load-use stall sequencing of LOAD_LAT cycles.
//                - Redirect flushing of FLUSH_DEPTH cycles.
//                - Sticky halt state, left only through reset.
//                - Saturating stall / flush event counters.
//  Ports       : clk, reset (sync, active-high)
//                id_*  : ID-stage sources and use flags
//                ex_*  : EX-stage sources, destination, write/load flags
//                mem_* / wb_* : downstream destinations and write enables
//                redirect, halt_in : control events
//                fwd_a, fwd_b : operand selects (0 RF, 1 MEM/WB, 2 EX/MEM)
//                pc_write, ifid_write, idex_bubble, ifid_flush, halted
//                stall_cnt, flush_cnt : saturating event counters
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_unit #(
   parameter int AW          = 2,
   parameter int LOAD_LAT    = 1,
   parameter int FLUSH_DEPTH = 1,
   parameter int CNT_W       = 16,
   parameter int ZERO_REG_EN = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [AW-1:0]    id_rs1,
   input  logic [AW-1:0]    id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic [AW-1:0]    ex_rs1,
   input  logic [AW-1:0]    ex_rs2,
   input  logic [AW-1:0]    ex_rd,
   input  logic             ex_reg_write,
   input  logic             ex_mem_read,
   input  logic [AW-1:0]    mem_rd,
   input  logic             mem_reg_write,
   input  logic [AW-1:0]    wb_rd,
   input  logic             wb_reg_write,
   input  logic             redirect,
   input  logic             halt_in,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             idex_bubble,
   output logic             ifid_flush,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   // Remaining cycles after the first one of a stall / flush sequence.
   localparam logic [2:0] C_STALL_RELOAD = 3'(LOAD_LAT - 1);
   localparam logic [2:0] C_FLUSH_RELOAD = 3'(FLUSH_DEPTH - 1);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_STALL  = 2'd1,
      ST_FLUSH  = 2'd2,
      ST_HALTED = 2'd3
   } state_t;

   state_t           r_state, w_state_next;
   logic [2:0]       r_cnt, w_cnt_next;
   logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
   logic             w_hazard, w_stall_evt, w_flush_evt;

   // ------------------------------------------------------------------------
   // Forwarding
   // ------------------------------------------------------------------------
   function automatic logic [1:0] fwd_sel(input logic [AW-1:0] src);
      if (ZERO_REG_EN != 0 && src == '0)
         return 2'd0;
      else if (mem_reg_write && mem_rd == src)
         return 2'd2;
      else if (wb_reg_write && wb_rd == src)
         return 2'd1;
      else
         return 2'd0;
   endfunction

   always_comb begin
      fwd_a = 2'd0;
      fwd_b = 2'd0;
      if (!reset) begin
         fwd_a = fwd_sel(ex_rs1);
         fwd_b = fwd_sel(ex_rs2);
      end
   end

   // ------------------------------------------------------------------------
   // Load-use detection
   // ------------------------------------------------------------------------
   always_comb begin
      w_hazard = ex_mem_read && ex_reg_write &&
                 ((id_use_rs1 && id_rs1 == ex_rd) ||
                  (id_use_rs2 && id_rs2 == ex_rd));
      if (ZERO_REG_EN != 0 && ex_rd == '0)
         w_hazard = 1'b0;
   end

   // ------------------------------------------------------------------------
   // Control FSM
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_RUN;
         r_cnt   <= 3'd0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
      end
   end

   // r_cnt holds the cycles still owed after the current one, so the
   // sequence ends when the current cycle sees a count of 1.
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      pc_write     = 1'b1;
      ifid_write   = 1'b1;
      idex_bubble  = 1'b0;
      ifid_flush   = 1'b0;
      w_stall_evt  = 1'b0;
      w_flush_evt  = 1'b0;

      if (reset) begin
         w_state_next = ST_RUN;
         w_cnt_next   = 3'd0;
      end else begin
         case (r_state)
            ST_RUN, ST_STALL: begin
               if (redirect) begin
                  // A redirect cancels any pending stall.
                  ifid_flush  = 1'b1;
                  idex_bubble = 1'b1;
                  w_flush_evt = 1'b1;
                  if (FLUSH_DEPTH > 1) begin
                     w_state_next = ST_FLUSH;
                     w_cnt_next   = C_FLUSH_RELOAD;
                  end else begin
                     w_state_next = ST_RUN;
                     w_cnt_next   = 3'd0;
                  end
               end else if (r_state == ST_STALL) begin
                  pc_write    = 1'b0;
                  ifid_write  = 1'b0;
                  idex_bubble = 1'b1;
                  w_stall_evt = 1'b1;
                  w_cnt_next  = r_cnt - 3'd1;
                  if (r_cnt <= 3'd1)
                     w_state_next = ST_RUN;
               end else if (w_hazard) begin
                  pc_write    = 1'b0;
                  ifid_write  = 1'b0;
                  idex_bubble = 1'b1;
                  w_stall_evt = 1'b1;
                  if (LOAD_LAT > 1) begin
                     w_state_next = ST_STALL;
                     w_cnt_next   = C_STALL_RELOAD;
                  end
               end else if (halt_in) begin
                  // HLT itself advances; only instruction fetch freezes.
                  pc_write     = 1'b0;
                  w_state_next = ST_HALTED;
               end
            end

            ST_FLUSH: begin
               ifid_flush = 1'b1;
               if (redirect) begin
                  idex_bubble = 1'b1;
                  w_flush_evt = 1'b1;
                  w_cnt_next  = C_FLUSH_RELOAD;
               end else begin
                  w_cnt_next = r_cnt - 3'd1;
                  if (r_cnt <= 3'd1)
                     w_state_next = ST_RUN;
               end
            end

            ST_HALTED: begin
               pc_write    = 1'b0;
               ifid_write  = 1'b0;
               idex_bubble = 1'b1;
            end

            default: begin
               w_state_next = ST_RUN;
               w_cnt_next   = 3'd0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Saturating event counters
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (w_stall_evt && r_stall_cnt != '1)
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         if (w_flush_evt && r_flush_cnt != '1)
            r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
   end

   // Reset values must be visible in the same cycle reset is asserted.
   assign halted    = (r_state == ST_HALTED) && !reset;
   assign stall_cnt = reset ? '0 : r_stall_cnt;
   assign flush_cnt = reset ? '0 : r_flush_cnt;

endmodule
`default_nettype wire
